// File: rtl/ex_pkg.sv
// Shared constants for the execute stage: ALU operation codes and datapath widths.
package ex_pkg;

   localparam int DATA_W   = 32;
   localparam int MD_ITERS = 32;
   localparam int REG_W    = 5;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_NOR   = 4'd5,
      ALU_SLT   = 4'd6,
      ALU_SLL   = 4'd7,
      ALU_SRL   = 4'd8,
      ALU_SRA   = 4'd9,
      ALU_LUI   = 4'd10,
      ALU_MULTU = 4'd11,
      ALU_DIVU  = 4'd12,
      ALU_MFHI  = 4'd13,
      ALU_MFLO  = 4'd14
   } alu_op_e;

   function automatic logic is_muldiv(input logic [3:0] op);
      return (op == ALU_MULTU) || (op == ALU_DIVU);
   endfunction

   function automatic logic is_hilo_read(input logic [3:0] op);
      return (op == ALU_MFHI) || (op == ALU_MFLO);
   endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, write-back forwarding source and EX/MEM outputs of the execute stage.
interface ex_stage_if #(parameter int W = 32);

   logic          id_valid;
   logic          RegWrite_in;
   logic          MemtoReg_in;
   logic          MemRead_in;
   logic          MemWrite_in;
   logic [3:0]    alu_op;
   logic          alu_src;
   logic [W-1:0]  rs_data;
   logic [W-1:0]  rt_data;
   logic [W-1:0]  imm;
   logic [4:0]    shamt;
   logic [4:0]    rs;
   logic [4:0]    rt;
   logic [4:0]    write_register_in;
   logic          wb_RegWrite;
   logic [4:0]    wb_rd;
   logic [W-1:0]  wb_data;

   logic          stall;
   logic          md_busy;
   logic          ExRegWrite_out;
   logic          ExMemtoReg_out;
   logic          MemRead_out;
   logic          MemWrite_out;
   logic [W-1:0]  alu_result_out;
   logic [W-1:0]  write_data_out;
   logic [4:0]    write_reg_out;

   modport master (
      output id_valid, RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, alu_op, alu_src,
             rs_data, rt_data, imm, shamt, rs, rt, write_register_in,
             wb_RegWrite, wb_rd, wb_data,
      input  stall, md_busy, ExRegWrite_out, ExMemtoReg_out, MemRead_out, MemWrite_out,
             alu_result_out, write_data_out, write_reg_out
   );

   modport slave (
      input  id_valid, RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, alu_op, alu_src,
             rs_data, rt_data, imm, shamt, rs, rt, write_register_in,
             wb_RegWrite, wb_rd, wb_data,
      output stall, md_busy, ExRegWrite_out, ExMemtoReg_out, MemRead_out, MemWrite_out,
             alu_result_out, write_data_out, write_reg_out
   );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) and divide (restoring) with HI/LO result registers.
module muldiv_unit #(
   parameter int W         = 32,
   parameter int MD_CYCLES = W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          op,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   output logic          busy,
   output logic [W-1:0]  hi,
   output logic [W-1:0]  lo
);

   localparam int CW = $clog2(MD_CYCLES + 1);

   logic [CW-1:0]   cnt_r;
   logic            op_r;
   logic [W-1:0]    opnd_r;
   logic [2*W-1:0]  work_r;
   logic [2*W-1:0]  work_nxt_s;
   logic [W:0]      add_s;
   logic [W:0]      sub_s;
   logic [2*W:0]    shl_s;
   logic [W-1:0]    hi_r;
   logic [W-1:0]    lo_r;

   // One iteration: work_r holds {partial, multiplier} or {remainder, dividend/quotient}.
   always_comb begin
      add_s = {1'b0, work_r[2*W-1:W]} + (work_r[0] ? {1'b0, opnd_r} : {(W+1){1'b0}});
      shl_s = {work_r, 1'b0};
      sub_s = shl_s[2*W:W] - {1'b0, opnd_r};
      if (op_r == 1'b0) begin
         work_nxt_s = {add_s, work_r[W-1:1]};
      end else if (sub_s[W] == 1'b0) begin
         work_nxt_s = {sub_s[W-1:0], shl_s[W-1:1], 1'b1};
      end else begin
         work_nxt_s = shl_s[2*W-1:0];
      end
   end

   // Operand capture, iteration counter and HI/LO commit on the final iteration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r  <= {CW{1'b0}};
         op_r   <= 1'b0;
         opnd_r <= {W{1'b0}};
         work_r <= {(2*W){1'b0}};
         hi_r   <= {W{1'b0}};
         lo_r   <= {W{1'b0}};
      end else if (start && (cnt_r == {CW{1'b0}})) begin
         cnt_r  <= CW'(MD_CYCLES);
         op_r   <= op;
         opnd_r <= b;
         work_r <= {{W{1'b0}}, a};
      end else if (cnt_r != {CW{1'b0}}) begin
         cnt_r  <= cnt_r - CW'(1);
         work_r <= work_nxt_s;
         if (cnt_r == CW'(1)) begin
            hi_r <= work_nxt_s[2*W-1:W];
            lo_r <= work_nxt_s[W-1:0];
         end
      end
   end

   assign busy = (cnt_r != {CW{1'b0}});
   assign hi   = hi_r;
   assign lo   = lo_r;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, multiply/divide hazard stall and the EX/MEM register.
module ex_stage
   import ex_pkg::*;
#(
   parameter int W         = ex_pkg::DATA_W,
   parameter int MD_CYCLES = ex_pkg::MD_ITERS
) (
   input logic        CLK,
   input logic        RST,
   ex_stage_if.slave  bus
);

   logic [W-1:0]  op_a_s;
   logic [W-1:0]  op_rt_s;
   logic [W-1:0]  op_b_s;
   logic [W-1:0]  alu_res_s;
   logic [W-1:0]  md_hi_s;
   logic [W-1:0]  md_lo_s;
   logic          ex_fwd_ok_s;
   logic          wb_fwd_ok_s;
   logic          is_md_s;
   logic          is_hilo_s;
   logic          md_busy_s;
   logic          md_start_s;
   logic          stall_s;

   logic          reg_write_r;
   logic          memto_reg_r;
   logic          mem_read_r;
   logic          mem_write_r;
   logic [W-1:0]  alu_result_r;
   logic [W-1:0]  write_data_r;
   logic [4:0]    write_reg_r;

   // A load in EX/MEM has no data yet, so it is never a forwarding source.
   assign ex_fwd_ok_s = reg_write_r & ~memto_reg_r & (write_reg_r != 5'd0);
   assign wb_fwd_ok_s = bus.wb_RegWrite & (bus.wb_rd != 5'd0);

   // Operand A forwarding, EX/MEM ahead of WB.
   always_comb begin
      if (ex_fwd_ok_s && (write_reg_r == bus.rs)) begin
         op_a_s = alu_result_r;
      end else if (wb_fwd_ok_s && (bus.wb_rd == bus.rs)) begin
         op_a_s = bus.wb_data;
      end else begin
         op_a_s = bus.rs_data;
      end
   end

   // rt forwarding, shared by operand B and store data.
   always_comb begin
      if (ex_fwd_ok_s && (write_reg_r == bus.rt)) begin
         op_rt_s = alu_result_r;
      end else if (wb_fwd_ok_s && (bus.wb_rd == bus.rt)) begin
         op_rt_s = bus.wb_data;
      end else begin
         op_rt_s = bus.rt_data;
      end
   end

   assign op_b_s = bus.alu_src ? bus.imm : op_rt_s;

   // ALU result selection.
   always_comb begin
      alu_res_s = {W{1'b0}};
      case (bus.alu_op)
         ALU_ADD:  alu_res_s = op_a_s + op_b_s;
         ALU_SUB:  alu_res_s = op_a_s - op_b_s;
         ALU_AND:  alu_res_s = op_a_s & op_b_s;
         ALU_OR:   alu_res_s = op_a_s | op_b_s;
         ALU_XOR:  alu_res_s = op_a_s ^ op_b_s;
         ALU_NOR:  alu_res_s = ~(op_a_s | op_b_s);
         ALU_SLT:  alu_res_s = {{(W-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
         ALU_SLL:  alu_res_s = op_b_s << bus.shamt;
         ALU_SRL:  alu_res_s = op_b_s >> bus.shamt;
         ALU_SRA:  alu_res_s = $signed(op_b_s) >>> bus.shamt;
         ALU_LUI:  alu_res_s = {bus.imm[15:0], {(W-16){1'b0}}};
         ALU_MFHI: alu_res_s = md_hi_s;
         ALU_MFLO: alu_res_s = md_lo_s;
         default:  alu_res_s = {W{1'b0}};
      endcase
   end

   assign is_md_s    = is_muldiv(bus.alu_op);
   assign is_hilo_s  = is_hilo_read(bus.alu_op);
   assign stall_s    = bus.id_valid & md_busy_s & (is_md_s | is_hilo_s);
   assign md_start_s = bus.id_valid & ~md_busy_s & is_md_s;

   muldiv_unit #(.W(W), .MD_CYCLES(MD_CYCLES)) u_muldiv (
      .clk   (CLK),
      .rst_n (RST),
      .start (md_start_s),
      .op    (bus.alu_op == ALU_DIVU),
      .a     (op_a_s),
      .b     (op_rt_s),
      .busy  (md_busy_s),
      .hi    (md_hi_s),
      .lo    (md_lo_s)
   );

   // EX/MEM register; MULTU/DIVU retire into it as a bubble.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         reg_write_r  <= 1'b0;
         memto_reg_r  <= 1'b0;
         mem_read_r   <= 1'b0;
         mem_write_r  <= 1'b0;
         alu_result_r <= {W{1'b0}};
         write_data_r <= {W{1'b0}};
         write_reg_r  <= 5'd0;
      end else if (!bus.id_valid || stall_s || is_md_s) begin
         reg_write_r  <= 1'b0;
         memto_reg_r  <= 1'b0;
         mem_read_r   <= 1'b0;
         mem_write_r  <= 1'b0;
         alu_result_r <= {W{1'b0}};
         write_data_r <= {W{1'b0}};
         write_reg_r  <= 5'd0;
      end else begin
         reg_write_r  <= bus.RegWrite_in;
         memto_reg_r  <= bus.MemtoReg_in;
         mem_read_r   <= bus.MemRead_in;
         mem_write_r  <= bus.MemWrite_in;
         alu_result_r <= alu_res_s;
         write_data_r <= op_rt_s;
         write_reg_r  <= bus.write_register_in;
      end
   end

   assign bus.stall          = stall_s;
   assign bus.md_busy        = md_busy_s;
   assign bus.ExRegWrite_out = reg_write_r;
   assign bus.ExMemtoReg_out = memto_reg_r;
   assign bus.MemRead_out    = mem_read_r;
   assign bus.MemWrite_out   = mem_write_r;
   assign bus.alu_result_out = alu_result_r;
   assign bus.write_data_out = write_data_r;
   assign bus.write_reg_out  = write_reg_r;

endmodule

// File: tb/tb_ex_stage.sv
// Random instruction stream against an architectural register/HI/LO model of the execute stage.
module tb_ex_stage;
   import ex_pkg::*;

   typedef struct {
      logic [3:0]  op;
      logic [4:0]  rs, rt, rd, sh;
      logic [31:0] imm;
      logic        src, rw, m2r, mr, mw;
   } instr_t;

   typedef struct {
      bit          wr;
      logic [4:0]  rd;
      logic [31:0] val;
   } wb_ent_t;

   typedef struct {
      bit          data;
      logic [3:0]  ctl;
      logic [31:0] res, wd;
      logic [4:0]  wr;
   } exp_t;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   ex_stage_if #(.W(32)) bus ();
   ex_stage #(.W(32), .MD_CYCLES(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   logic [31:0] arch [32];
   logic [31:0] rf   [32];
   logic [31:0] hi_m = 32'd0, lo_m = 32'd0, pend_hi, pend_lo;
   bit          pend = 1'b0;
   int          md_done = 0;
   int          cyc = 0;
   wb_ent_t     e1, e2, e3, bub;
   exp_t        exq;

   function automatic logic [3:0] ctl_of(input instr_t i);
      return {i.rw, i.m2r, i.mr, i.mw};
   endfunction

   function automatic logic [31:0] ref_alu(input instr_t i, input logic [31:0] a, input logic [31:0] rtv);
      logic [31:0] b = i.src ? i.imm : rtv;
      logic [15:0] lo16 = i.imm[15:0];
      case (i.op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         ALU_NOR:  return ~(a | b);
         ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLL:  return b << i.sh;
         ALU_SRL:  return b >> i.sh;
         ALU_SRA:  return $signed(b) >>> i.sh;
         ALU_LUI:  return {lo16, 16'h0000};
         ALU_MFHI: return hi_m;
         ALU_MFLO: return lo_m;
         default:  return 32'd0;
      endcase
   endfunction

   function automatic instr_t gen(input int n);
      instr_t i;
      int k = $urandom_range(0, 99);
      i.rs = 5'($urandom_range(0, 7));
      i.rt = 5'($urandom_range(0, 7));
      i.rd = 5'($urandom_range(0, 7));
      i.sh = 5'($urandom);
      i.imm = ($urandom_range(0, 1) == 0) ? 32'($urandom) : {{16{1'b0}}, 16'($urandom_range(0, 64))};
      i.src = 1'b0; i.rw = 1'b1; i.m2r = 1'b0; i.mr = 1'b0; i.mw = 1'b0;
      if (n < 2) begin
         i.op = (n == 0) ? ALU_MFHI : ALU_MFLO;
      end else if (k < 6) begin
         i.op = ($urandom_range(0, 1) == 0) ? ALU_MULTU : ALU_DIVU;
         i.rw = 1'($urandom_range(0, 1));
         if (i.op == ALU_DIVU && $urandom_range(0, 3) == 0) i.rt = 5'd0;
      end else if (k < 16) begin
         i.op = ($urandom_range(0, 1) == 0) ? ALU_MFHI : ALU_MFLO;
      end else if (k < 22) begin
         i.op = ALU_ADD; i.src = 1'b1; i.rw = 1'b0; i.mw = 1'b1;
      end else if (k < 26) begin
         i.op = ALU_ADD; i.src = 1'b1; i.rd = 5'd0; i.m2r = 1'b1; i.mr = 1'b1;
      end else begin
         i.op = 4'($urandom_range(0, 10));
         i.src = (i.op == ALU_LUI) || (i.op <= ALU_SLT && $urandom_range(0, 3) == 0);
      end
      return i;
   endfunction

   task automatic drive(input bit v, input instr_t i);
      bus.id_valid          = v;
      bus.alu_op            = i.op;
      bus.alu_src           = i.src;
      bus.RegWrite_in       = i.rw;
      bus.MemtoReg_in       = i.m2r;
      bus.MemRead_in        = i.mr;
      bus.MemWrite_in       = i.mw;
      bus.rs                = i.rs;
      bus.rt                = i.rt;
      bus.write_register_in = i.rd;
      bus.imm               = i.imm;
      bus.shamt             = i.sh;
      bus.rs_data           = rf[i.rs];
      bus.rt_data           = rf[i.rt];
      bus.wb_RegWrite       = e2.wr;
      bus.wb_rd             = e2.rd;
      bus.wb_data           = e2.val;
   endtask

   task automatic chk_exmem_zero(input string tag);
      chk_eq({tag, "_ctl"}, {28'd0, bus.ExRegWrite_out, bus.ExMemtoReg_out, bus.MemRead_out, bus.MemWrite_out}, 32'd0);
      chk_eq({tag, "_res"}, bus.alu_result_out, 32'd0);
      chk_eq({tag, "_wd"},  bus.write_data_out, 32'd0);
      chk_eq({tag, "_wr"},  {27'd0, bus.write_reg_out}, 32'd0);
      chk_eq({tag, "_busy"}, {31'd0, bus.md_busy}, 32'd0);
   endtask

   initial begin
      instr_t cur, idle;
      bit     cur_v = 1'b0, have_cur = 1'b0;
      bit     busy_m, stall_m;
      logic [63:0] p;
      logic [31:0] a, rtv, res;
      int     n = 0;

      bub = '{wr: 1'b0, rd: 5'd0, val: 32'd0};
      e1 = bub; e2 = bub; e3 = bub;
      for (int r = 0; r < 32; r++) begin
         rf[r] = (r == 0) ? 32'd0 : 32'($urandom);
         arch[r] = rf[r];
      end
      idle = '{op: ALU_ADD, rs: 5'd0, rt: 5'd0, rd: 5'd0, sh: 5'd0, imm: 32'd0,
               src: 1'b0, rw: 1'b0, m2r: 1'b0, mr: 1'b0, mw: 1'b0};
      drive(1'b0, idle);

      // reset state, then a MULTU aborted by reset at busy cycle 10
      repeat (2) @(posedge CLK);
      #1;
      chk_exmem_zero("rst");
      @(negedge CLK) RST = 1'b1;
      @(posedge CLK); #1;
      cur = idle; cur.op = ALU_MULTU; cur.rs = 5'd1; cur.rt = 5'd2;
      drive(1'b1, cur);
      bus.rs_data = 32'hFFFF_FFFF; bus.rt_data = 32'd2;
      @(posedge CLK); #1;
      drive(1'b0, idle);
      chk_eq("md_busy_t1", {31'd0, bus.md_busy}, 32'd1);
      repeat (8) @(posedge CLK);
      #1;
      cur = idle; cur.op = ALU_ADD; cur.rs = 5'd1; cur.rt = 5'd2; cur.rd = 5'd3; cur.rw = 1'b1;
      drive(1'b1, cur);
      bus.rs_data = 32'd5; bus.rt_data = 32'd7;
      @(posedge CLK); #1;
      drive(1'b0, idle);
      chk_eq("add_5_7", bus.alu_result_out, 32'd12);
      chk_eq("md_busy_t10", {31'd0, bus.md_busy}, 32'd1);
      #2 RST = 1'b0;
      #1;
      chk_exmem_zero("abort");
      #3 RST = 1'b1;

      // random stream; first two instructions read HI/LO after the abort
      exq = '{data: 1'b1, ctl: 4'd0, res: 32'd0, wd: 32'd0, wr: 5'd0};
      while (n < 1500) begin
         @(posedge CLK); #1;
         chk_eq("ctl", {28'd0, bus.ExRegWrite_out, bus.ExMemtoReg_out, bus.MemRead_out, bus.MemWrite_out},
                {28'd0, exq.ctl});
         if (exq.data) begin
            chk_eq("alu_result", bus.alu_result_out, exq.res);
            chk_eq("write_data", bus.write_data_out, exq.wd);
            chk_eq("write_reg", {27'd0, bus.write_reg_out}, {27'd0, exq.wr});
         end
         cyc++;
         if (e3.wr && e3.rd != 5'd0) rf[e3.rd] = e3.val;
         if (pend && cyc >= md_done) begin
            hi_m = pend_hi; lo_m = pend_lo; pend = 1'b0;
         end
         if (!have_cur) begin
            cur = gen(n);
            cur_v = (n < 2) || ($urandom_range(0, 9) != 0);
            have_cur = 1'b1;
         end
         drive(cur_v, cur);
         #1;
         busy_m  = (cyc < md_done);
         stall_m = cur_v && busy_m &&
                   (cur.op == ALU_MULTU || cur.op == ALU_DIVU || cur.op == ALU_MFHI || cur.op == ALU_MFLO);
         chk_eq("md_busy", {31'd0, bus.md_busy}, {31'd0, busy_m});
         chk_eq("stall", {31'd0, bus.stall}, {31'd0, stall_m});

         e3 = e2; e2 = e1;
         if (!cur_v || stall_m) begin
            e1 = bub;
            exq = '{data: 1'b1, ctl: 4'd0, res: 32'd0, wd: 32'd0, wr: 5'd0};
            if (!cur_v) have_cur = 1'b0;
         end else begin
            a   = arch[cur.rs];
            rtv = arch[cur.rt];
            if (cur.op == ALU_MULTU || cur.op == ALU_DIVU) begin
               if (cur.op == ALU_MULTU) p = {32'd0, a} * {32'd0, rtv};
               else if (rtv == 32'd0)   p = {a, 32'hFFFF_FFFF};
               else                     p = {a % rtv, a / rtv};
               pend_hi = p[63:32]; pend_lo = p[31:0]; pend = 1'b1;
               md_done = cyc + 33;
               e1 = bub;
               exq = '{data: 1'b0, ctl: 4'd0, res: 32'd0, wd: 32'd0, wr: 5'd0};
            end else begin
               res = ref_alu(cur, a, rtv);
               exq = '{data: 1'b1, ctl: ctl_of(cur), res: res, wd: rtv, wr: cur.rd};
               e1 = '{wr: cur.rw, rd: cur.rd, val: cur.m2r ? 32'($urandom) : res};
               if (cur.rw && !cur.m2r && cur.rd != 5'd0) arch[cur.rd] = res;
            end
            have_cur = 1'b0;
            n++;
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS-style pipeline, directly upstream of the memory stage.
- Performs operand forwarding, ALU operations and an iterative 32-cycle unsigned multiply/divide unit with HI/LO registers.
- Issues a stall request to the earlier stages when a multiply/divide resource hazard occurs.
- Ends in the EX/MEM pipeline register whose outputs feed the memory stage: address, writeData, write_register, MemRead, MemWrite, ExRegWrite_in, ExMemtoReg_in.

Parameters:
- W, 32, datapath width
- MD_CYCLES, 32, iterations of the multiply/divide unit (equal to W)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- id_valid  in  1  ID/EX holds a valid instruction
- RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in  in  1 each  control bits from ID/EX
- alu_op  in  4  operation code (package constants)
- alu_src  in  1  1 = operand B is imm
- rs_data, rt_data  in  W  register file read data
- imm  in  W  sign-extended immediate
- shamt  in  5  shift amount
- rs, rt  in  5  source register numbers
- write_register_in  in  5  destination register
- wb_RegWrite, wb_rd, wb_data  in  1/5/W  write-back forwarding source
- stall  out  1  hold PC, IF/ID and ID/EX this cycle
- md_busy  out  1  multiply/divide in progress
- ExRegWrite_out, ExMemtoReg_out, MemRead_out, MemWrite_out  out  1 each  EX/MEM control
- alu_result_out  out  W  result; memory address for loads and stores
- write_data_out  out  W  forwarded rt value, used as store data
- write_reg_out  out  5  destination register

Behaviour:
- Reset (RST=0, asynchronous): all EX/MEM outputs 0, HI=LO=0, md_busy=0, iteration counter 0. An in-flight multiply/divide is aborted.
- Forwarding, applied per operand (rs→A, rt→B/store data):
  - EX/MEM source (own registered outputs): used if ExRegWrite_out=1, ExMemtoReg_out=0, write_reg_out≠0 and write_reg_out matches the operand register.
  - Otherwise WB source: used if wb_RegWrite=1, wb_rd≠0 and wb_rd matches.
  - Otherwise the register file value.
  - EX/MEM has priority over WB.
  - Load-use hazards are resolved by the ID hazard unit; this block never forwards a load result from EX/MEM.
- ALU operations, result width W, wrap-around, no overflow trap:
  - ADD, SUB, AND, OR, XOR, NOR
  - SLT: signed compare, result 1 or 0
  - SLL, SRL, SRA: shift B by shamt
  - LUI: {imm[15:0], 16'b0}
  - MFHI, MFLO: read HI or LO
- MULTU / DIVU:
  - Accepted when id_valid=1 and md_busy=0 in cycle t. Operands are latched, the counter is loaded with MD_CYCLES, and md_busy=1 for cycles t+1..t+32.
  - HI/LO update at the edge ending cycle t+32; md_busy=0 in cycle t+33.
  - MULTU: shift-add, {HI,LO} = A*B (64-bit product).
  - DIVU: restoring division, LO=quotient, HI=remainder. Divide by zero: LO=all ones, HI=A.
  - The instruction itself passes to EX/MEM as a no-op (RegWrite=0), so independent instructions proceed while md_busy=1.
- Stall:
  - stall = id_valid & md_busy & (alu_op is MULTU, DIVU, MFHI or MFLO); combinational.
  - While stall=1, EX/MEM loads a bubble: all four control bits 0, data outputs don't-care (registered as 0). Upstream holds ID/EX.
  - On the last busy cycle stall=1. MFHI issued in the next cycle reads the new HI.
- Normal advance: when id_valid=0, EX/MEM loads a bubble. Otherwise the EX/MEM register loads every cycle with latency 1: the result is visible on alu_result_out in the cycle after the instruction is in EX.
- Simultaneous events: a second MULTU/DIVU while busy stalls, and is accepted in the first cycle md_busy=0.

Decomposition:
- Package ex_pkg: ALU_ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLL=7, SRL=8, SRA=9, LUI=10, MULTU=11, DIVU=12, MFHI=13, MFLO=14; width constants.
- Sub-module muldiv_unit:
  - Inputs: start, op, a, b.
  - Outputs: busy, hi, lo.
  - Contains the counter, shift registers and HI/LO.
- Forwarding muxes, ALU and EX/MEM register stay in ex_stage.

Test Plan:
- Reset mid-multiply: MULTU started, RST low at busy cycle 10 → md_busy=0, HI=LO=0, all outputs 0 immediately (asynchronous).
- ADD r3=r1+r2 with r1=5, r2=7, then SUB r4=r3-r1 next cycle (stale rs_data=0) → alu_result_out 12, then 7 via EX/MEM forward; r0 destination with value 9 never forwarded.
- WB and EX/MEM both target r5 (wb_data=1, EX/MEM=2), next instruction reads r5 → EX/MEM value 2 wins.
- MULTU 0xFFFFFFFF×2, then MFHI at t+1 → stall high for cycles t+1..t+32 with bubbles in EX/MEM; MFHI result 0x00000001, MFLO 0xFFFFFFFE.
- DIVU 100/7 then DIVU 5/0 → LO=14, HI=2; then LO=0xFFFFFFFF, HI=5.
- SW with rt forwarded from WB (wb_data=0xDEADBEEF), base 0x10, imm 4 → alu_result_out 0x14, write_data_out 0xDEADBEEF, MemWrite_out=1.
